ili_spi_responder: RTL
======================

# ili_spi_responder

Display-side SPI responder that models the ILI9341 serial interface. It receives the 4-wire stream produced by the panel initialisation master (sclk, mosi, dc, cs, active-low panel reset) and deserialises it into bytes. Each byte is tagged as command or parameter, and parameters are indexed within their command. The block also returns a loadable byte on miso. It sits on the far end of the display link and serves as the bus-functional responder in system benches and as a synthesizable loopback target on the board.

## Interface
Parameters:
- SYNC_STAGES, 2, synchroniser depth on sclk/mosi/dc/cs/resx_n (legal ≥ 2)
- PIDX_W, 4, width of the parameter index (saturates at 2^PIDX_W−1)

Ports:
- clk  in  1  system clock; every register is clocked on its rising edge
- rst  in  1  synchronous, active-high reset
- sclk  in  1  SPI clock from master, asynchronous to clk, idle low (mode 0)
- mosi  in  1  serial data from master, MSB first
- cs  in  1  chip select, active low
- dc  in  1  0 = command byte, 1 = parameter/data byte; sampled with bit 0
- resx_n  in  1  panel hardware reset, active low
- tx_data  in  8  byte to return on miso
- tx_load  in  1  one-cycle strobe that captures tx_data
- miso  out  1  serial data to master, MSB first
- rx_data  out  8  last received byte
- rx_valid  out  1  one-cycle pulse when a byte completes
- rx_is_cmd  out  1  dc==0 for the byte in rx_data
- cmd  out  8  most recent command byte
- param_idx  out  PIDX_W  index of the byte in rx_data within the current command
- frame_err  out  1  one-cycle pulse when cs rises mid-byte

## Operation
- All serial inputs pass through SYNC_STAGES flops. One extra register holds the previous sclk and cs. These give sclk_rise, sclk_fall, cs_fall and cs_rise, all derived from the synchronised values.
- States: IDLE (cs high), SHIFT (cs low). IDLE→SHIFT on cs_fall. SHIFT→IDLE on cs_rise.
- IDLE behaviour:
  - bit_cnt = 0.
  - miso = 0.
  - The shift register is cleared.
- SHIFT, on sclk_rise:
  - sr ← {sr[6:0], mosi_s}.
  - bit_cnt increments (3-bit, wraps 7→0).
  - When bit_cnt was 7, the byte is complete:
    - rx_data ← {sr[6:0], mosi_s}.
    - rx_is_cmd ← ~dc_s.
    - rx_valid pulses.
- Byte classification on completion:
  - Command byte: cmd ← byte, param_idx ← 0, and the next-parameter counter is set to 0.
  - Data byte: param_idx ← counter, then the counter increments, saturating at 2^PIDX_W−1.
  - A data byte with no prior command since reset reports cmd = 0x00.
- MISO path:
  - tx_load captures tx_data into tx_hold, whatever the state.
  - On cs_fall, and on each byte completion, tx_sr ← tx_hold.
  - miso = tx_sr[7]. tx_sr shifts left on each sclk_fall that is not the falling edge following the byte-completion rise.
  - Without a new tx_load, the same tx_hold byte is repeated.
- frame_err: pulses on cs_rise when bit_cnt ≠ 0. The partial byte is discarded, with no rx_valid and no cmd/param change.
- resx_n_s low behaves as rst for cmd, param counter, rx_data, rx_is_cmd, tx_hold and the FSM. rx_valid and frame_err are forced to 0.
- Simultaneous events:
  - tx_load in the same cycle as a byte completion: the new tx_data goes into both tx_hold and tx_sr.
  - cs_rise in the same cycle as sclk_rise: the cs_rise wins and the sclk edge is ignored.

## Timing
- Reset values:
  - miso 0, rx_data 0x00, rx_valid 0, rx_is_cmd 0, cmd 0x00, param_idx 0, frame_err 0.
  - tx_hold 0x00, FSM IDLE.
- Latency: rx_valid is asserted SYNC_STAGES+1 clk cycles after the first clk edge at which raw sclk is sampled high for bit 7. rx_data, rx_is_cmd, cmd and param_idx are valid in that same cycle and hold until the next completion.
- miso changes SYNC_STAGES+1 cycles after a raw sclk fall or cs fall is sampled.
- Input constraints: sclk high and sclk low must each last ≥ SYNC_STAGES+2 clk cycles. cs setup to the first sclk rise must be ≥ SYNC_STAGES+2 cycles. mosi and dc must be stable from sclk fall to after sclk rise.
- rx_valid and frame_err never assert in the same cycle.
- Back-to-back bytes with cs held low are legal; the bit counter simply wraps.
- rst mid-byte: the next byte is counted from cs_fall or from the bit_cnt=0 boundary. Stimulus must drop cs after reset.

## Test plan
- Command 0x01 (dc=0) → one rx_valid, rx_data=0x01, rx_is_cmd=1, cmd=0x01, param_idx=0, latency exactly SYNC_STAGES+1 after the 8th sclk rise.
- Frame 0xC0 (dc=0), 0x23 (dc=1), 0x10 (dc=1) in one cs window → three rx_valid pulses. Parameters report cmd=0xC0 with param_idx 0 then 1, rx_data 0x23 then 0x10.
- 17 parameter bytes after command 0x2C → param_idx sequence 0…15, then 15 again (saturation). cmd stays 0x2C.
- cs raised after 5 bits of 0xFF → frame_err single pulse, no rx_valid, cmd unchanged. Next full byte 0xA5 (dc=1) is received correctly.
- tx_load with 0x93 before cs_fall, then 16 sclk cycles → miso bit sequence 1,0,0,1,0,0,1,1 repeated twice.
- resx_n low for 10 cycles after command 0x36 → cmd=0x00 and no pulses. rst asserted mid-byte → all outputs at their reset values the next cycle.

Source files
------------

// File: rtl/ili_spi_responder.sv
// ILI9341-style SPI responder: deserialises the 4-wire display link into tagged
// command/parameter bytes and returns a loadable byte on miso.
module ili_spi_responder #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned PIDX_W      = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              sclk_i,
    input  logic              mosi_i,
    input  logic              cs_i,
    input  logic              dc_i,
    input  logic              resx_n_i,
    input  logic [7:0]        tx_data_i,
    input  logic              tx_load_i,
    output logic              miso_o,
    output logic [7:0]        rx_data_o,
    output logic              rx_valid_o,
    output logic              rx_is_cmd_o,
    output logic [7:0]        cmd_o,
    output logic [PIDX_W-1:0] param_idx_o,
    output logic              frame_err_o
);

    typedef enum logic [0:0] {StIdle, StShift} state_e;

    // Synchroniser lanes packed as {resx_n, cs, dc, mosi, sclk}; idle values on reset.
    localparam logic [4:0] SyncIdle = 5'b11000;

    logic [4:0] sync_q [SYNC_STAGES];
    logic       sclk_s, mosi_s, dc_s, cs_s, resx_n_s;
    logic       sclk_prev_q, cs_prev_q;
    logic       sclk_rise_q, sclk_fall_q, cs_rise_q, cs_fall_q;

    state_e            state_q, state_d;
    logic [2:0]        bit_cnt_q, bit_cnt_d;
    logic [7:0]        sr_q, sr_d;
    logic [7:0]        rx_data_q, rx_data_d;
    logic              rx_valid_q, rx_valid_d;
    logic              rx_is_cmd_q, rx_is_cmd_d;
    logic [7:0]        cmd_q, cmd_d;
    logic [PIDX_W-1:0] param_idx_q, param_idx_d;
    logic [PIDX_W-1:0] pcnt_q, pcnt_d;
    logic              frame_err_q, frame_err_d;
    logic [7:0]        tx_hold_q, tx_hold_d;
    logic [7:0]        tx_sr_q, tx_sr_d;
    logic              skip_fall_q, skip_fall_d;

    logic [7:0] rx_byte;

    assign {resx_n_s, cs_s, dc_s, mosi_s, sclk_s} = sync_q[SYNC_STAGES-1];
    assign rx_byte = {sr_q[6:0], mosi_s};

    // Synchronise the serial inputs and register edge pulses of sclk and cs.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= SyncIdle;
            end
            sclk_prev_q <= 1'b0;
            cs_prev_q   <= 1'b1;
            sclk_rise_q <= 1'b0;
            sclk_fall_q <= 1'b0;
            cs_rise_q   <= 1'b0;
            cs_fall_q   <= 1'b0;
        end else begin
            sync_q[0] <= {resx_n_i, cs_i, dc_i, mosi_i, sclk_i};
            for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            sclk_prev_q <= sclk_s;
            cs_prev_q   <= cs_s;
            sclk_rise_q <= sclk_s & ~sclk_prev_q;
            sclk_fall_q <= ~sclk_s & sclk_prev_q;
            cs_rise_q   <= cs_s & ~cs_prev_q;
            cs_fall_q   <= ~cs_s & cs_prev_q;
        end
    end

    // FSM next state: IDLE while cs is high, SHIFT while it is low; panel reset forces IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (cs_fall_q) state_d = StShift;
            StShift: if (cs_rise_q) state_d = StIdle;
            default: state_d = StIdle;
        endcase
        if (!resx_n_s) state_d = StIdle;
    end

    // Datapath next state: shifting, byte completion, classification and the miso shifter.
    always_comb begin
        bit_cnt_d   = bit_cnt_q;
        sr_d        = sr_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = 1'b0;
        rx_is_cmd_d = rx_is_cmd_q;
        cmd_d       = cmd_q;
        param_idx_d = param_idx_q;
        pcnt_d      = pcnt_q;
        frame_err_d = 1'b0;
        tx_hold_d   = tx_load_i ? tx_data_i : tx_hold_q;
        tx_sr_d     = tx_sr_q;
        skip_fall_d = skip_fall_q;

        if (state_q == StIdle) begin
            bit_cnt_d   = 3'd0;
            sr_d        = 8'h00;
            skip_fall_d = 1'b0;
            // tx_hold_d so a load in this very cycle is what gets shifted out
            if (cs_fall_q) tx_sr_d = tx_hold_d;
        end else if (cs_rise_q) begin
            // cs_rise wins over any coincident sclk edge; a partial byte is dropped
            frame_err_d = (bit_cnt_q != 3'd0);
            bit_cnt_d   = 3'd0;
            sr_d        = 8'h00;
        end else begin
            if (sclk_rise_q) begin
                sr_d      = rx_byte;
                bit_cnt_d = bit_cnt_q + 3'd1;
                if (bit_cnt_q == 3'd7) begin
                    rx_data_d   = rx_byte;
                    rx_valid_d  = 1'b1;
                    rx_is_cmd_d = ~dc_s;
                    if (!dc_s) begin
                        cmd_d       = rx_byte;
                        param_idx_d = '0;
                        pcnt_d      = '0;
                    end else begin
                        param_idx_d = pcnt_q;
                        if (pcnt_q != '1) pcnt_d = pcnt_q + {{(PIDX_W-1){1'b0}}, 1'b1};
                    end
                    tx_sr_d     = tx_hold_d;
                    skip_fall_d = 1'b1;
                end
            end
            if (sclk_fall_q) begin
                // The fall right after a completion must keep the freshly loaded MSB.
                if (skip_fall_q) skip_fall_d = 1'b0;
                else             tx_sr_d     = {tx_sr_q[6:0], 1'b0};
            end
        end

        if (!resx_n_s) begin
            bit_cnt_d   = 3'd0;
            sr_d        = 8'h00;
            rx_data_d   = 8'h00;
            rx_valid_d  = 1'b0;
            rx_is_cmd_d = 1'b0;
            cmd_d       = 8'h00;
            param_idx_d = '0;
            pcnt_d      = '0;
            frame_err_d = 1'b0;
            tx_hold_d   = 8'h00;
            tx_sr_d     = 8'h00;
            skip_fall_d = 1'b0;
        end
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= StIdle;
            bit_cnt_q   <= 3'd0;
            sr_q        <= 8'h00;
            rx_data_q   <= 8'h00;
            rx_valid_q  <= 1'b0;
            rx_is_cmd_q <= 1'b0;
            cmd_q       <= 8'h00;
            param_idx_q <= '0;
            pcnt_q      <= '0;
            frame_err_q <= 1'b0;
            tx_hold_q   <= 8'h00;
            tx_sr_q     <= 8'h00;
            skip_fall_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            sr_q        <= sr_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            rx_is_cmd_q <= rx_is_cmd_d;
            cmd_q       <= cmd_d;
            param_idx_q <= param_idx_d;
            pcnt_q      <= pcnt_d;
            frame_err_q <= frame_err_d;
            tx_hold_q   <= tx_hold_d;
            tx_sr_q     <= tx_sr_d;
            skip_fall_q <= skip_fall_d;
        end
    end

    // Outputs; miso is held low outside a cs window.
    always_comb begin
        miso_o      = (state_q == StShift) ? tx_sr_q[7] : 1'b0;
        rx_data_o   = rx_data_q;
        rx_valid_o  = rx_valid_q;
        rx_is_cmd_o = rx_is_cmd_q;
        cmd_o       = cmd_q;
        param_idx_o = param_idx_q;
        frame_err_o = frame_err_q;
    end

endmodule
